// File: rtl/noc_pkg.sv
// Shared flit helpers for the hierarchical NoC and its PE-side interfaces.
// Latency: n/a (package only: types, localparams, pure functions).
// Backpressure: n/a.
// Helpers work on a MaxW-bit container so that one set of functions serves
// any DataWidth/AddrWidth pairing; callers zero-extend in and size-cast out.
package noc_pkg;

    localparam int MaxW = 64;

    typedef logic [MaxW-1:0] wide_t;

    // Round-robin pointer for the RX write arbiter.
    typedef enum logic {
        PRIO_NOC  = 1'b0,
        PRIO_LOOP = 1'b1
    } prio_e;

    function automatic int flit_width(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    // Flit layout is {dest, data}, with dest sitting directly above the payload.
    function automatic wide_t flit_pack(input wide_t dest, input wide_t data, input int data_w);
        return (dest << data_w) | data;
    endfunction

    function automatic wide_t flit_dest(input wide_t flit, input int data_w);
        return flit >> data_w;
    endfunction

    function automatic wide_t flit_data(input wide_t flit, input int data_w);
        return flit & ((wide_t'(1) << data_w) - wide_t'(1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and full/empty flags.
// Latency: push at edge N is visible at o_rdata after edge N; no fall-through.
// Backpressure: push ignored when full, pop ignored when empty; no pop-bypass.
// Ports: i_clk/i_reset, i_push/i_wdata write side, i_pop/o_rdata read side,
// o_full/o_empty status. Depth must be a power of two >= 2.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [Width-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0]   mem_q [Depth];
    logic               push_ok;
    logic               pop_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_rdata = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through a non-empty FIFO.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q[PtrW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-side NoC interface: packs/injects TX flits, ejects RX flits, loops self-addressed traffic back.
// Latency: TX accept -> o_noc_valid next cycle; loopback -> o_pe_valid 2 cycles; NoC eject -> 1 cycle.
// Backpressure: o_pe_ready = !tx_full; o_noc_ready = !rx_full unless loopback holds the RX grant.
// Ports: i_pe_* / o_pe_ready PE TX side; o_noc_* / i_noc_ready injection; i_noc_* / o_noc_ready
// ejection; o_pe_* / i_pe_ready PE RX side; o_tx_count, o_rx_count, o_misroute status.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 4,
    parameter int MyAddr    = 0,
    parameter int FifoDepth = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic [DataWidth-1:0]                          i_pe_data,
    input  logic [AddrWidth-1:0]                          i_pe_dest,
    input  logic                                          i_pe_valid,
    output logic                                          o_pe_ready,
    output logic [flit_width(DataWidth, AddrWidth)-1:0]   o_noc_data,
    output logic                                          o_noc_valid,
    input  logic                                          i_noc_ready,
    input  logic [flit_width(DataWidth, AddrWidth)-1:0]   i_noc_data,
    input  logic                                          i_noc_valid,
    output logic                                          o_noc_ready,
    output logic [DataWidth-1:0]                          o_pe_data,
    output logic                                          o_pe_local,
    output logic                                          o_pe_valid,
    input  logic                                          i_pe_ready,
    output logic [15:0]                                   o_tx_count,
    output logic [15:0]                                   o_rx_count,
    output logic                                          o_misroute
);

    localparam int    FW      = flit_width(DataWidth, AddrWidth);
    localparam wide_t MyAddrW = wide_t'(MyAddr);

    logic [FW-1:0]        tx_wdata, tx_head;
    logic                 tx_full, tx_empty, tx_pop;
    logic [DataWidth:0]   rx_wdata, rx_head;
    logic                 rx_full, rx_empty, rx_push;
    logic                 loop_req, loop_grant, noc_fire, noc_accept, noc_dest_me;
    prio_e                prio_q, prio_d;
    logic [15:0]          tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic                 misroute_q, misroute_d;

    assign tx_wdata = FW'(flit_pack(wide_t'(i_pe_dest), wide_t'(i_pe_data), DataWidth));

    sync_fifo #(.Width(FW), .Depth(FifoDepth)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_pe_valid),
        .i_wdata (tx_wdata),
        .i_pop   (tx_pop),
        .o_rdata (tx_head),
        .o_full  (tx_full),
        .o_empty (tx_empty)
    );

    sync_fifo #(.Width(DataWidth + 1), .Depth(FifoDepth)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (rx_push),
        .i_wdata (rx_wdata),
        .i_pop   (i_pe_ready),
        .o_rdata (rx_head),
        .o_full  (rx_full),
        .o_empty (rx_empty)
    );

    // A self-addressed head never reaches the NoC; it waits for an RX grant
    // instead, blocking whatever queues behind it.
    assign loop_req    = !tx_empty && (flit_dest(wide_t'(tx_head), DataWidth) == MyAddrW);
    assign noc_dest_me = (flit_dest(wide_t'(i_noc_data), DataWidth) == MyAddrW);

    assign o_pe_ready  = !tx_full;
    assign o_noc_valid = !tx_empty && !loop_req;
    assign o_noc_data  = o_noc_valid ? tx_head : '0;
    assign noc_fire    = o_noc_valid && i_noc_ready;

    // NoC ready does not look at i_noc_valid: it only withdraws when loopback
    // holds the round-robin turn and is actually requesting.
    assign o_noc_ready = !rx_full && !(loop_req && prio_q == PRIO_LOOP);
    assign noc_accept  = i_noc_valid && o_noc_ready;
    assign loop_grant  = loop_req && !rx_full && !(i_noc_valid && prio_q == PRIO_NOC);
    assign tx_pop      = noc_fire || loop_grant;

    // Misrouted flits consume the grant but are dropped here.
    assign rx_push  = loop_grant || (noc_accept && noc_dest_me);
    assign rx_wdata = loop_grant
                    ? {1'b1, DataWidth'(flit_data(wide_t'(tx_head), DataWidth))}
                    : {1'b0, DataWidth'(flit_data(wide_t'(i_noc_data), DataWidth))};

    assign o_pe_valid = !rx_empty;
    assign o_pe_data  = rx_empty ? '0 : rx_head[DataWidth-1:0];
    assign o_pe_local = !rx_empty && rx_head[DataWidth];

    always_comb begin
        prio_d     = prio_q;
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        misroute_d = misroute_q;
        // Pointer only moves on a contested, granted cycle.
        if (loop_req && i_noc_valid && !rx_full)
            prio_d = (prio_q == PRIO_NOC) ? PRIO_LOOP : PRIO_NOC;
        if (noc_fire) tx_count_d = tx_count_q + 16'd1;
        if (rx_push)  rx_count_d = rx_count_q + 16'd1;
        if (noc_accept && !noc_dest_me) misroute_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prio_q     <= PRIO_NOC;
            tx_count_q <= '0;
            rx_count_q <= '0;
            misroute_q <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            misroute_q <= misroute_d;
        end
    end

    assign o_tx_count = tx_count_q;
    assign o_rx_count = rx_count_q;
    assign o_misroute = misroute_q;

endmodule

// File: tb/tb_noc_pe_interface.sv
module tb_noc_pe_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pe_data;
    logic [3:0]  pe_dest;
    logic        pe_valid, pe_ready;
    logic [35:0] noc_data_o, noc_data_i;
    logic        noc_valid_o, noc_ready_i, noc_valid_i, noc_ready_o;
    logic [31:0] pe_data_o;
    logic        pe_local, pe_valid_o, pe_ready_i;
    logic [15:0] tx_count, rx_count;
    logic        misroute;

    always #5 clk = ~clk;

    noc_pe_interface #(.DataWidth(32), .AddrWidth(4), .MyAddr(0), .FifoDepth(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_pe_data(pe_data), .i_pe_dest(pe_dest), .i_pe_valid(pe_valid), .o_pe_ready(pe_ready),
        .o_noc_data(noc_data_o), .o_noc_valid(noc_valid_o), .i_noc_ready(noc_ready_i),
        .i_noc_data(noc_data_i), .i_noc_valid(noc_valid_i), .o_noc_ready(noc_ready_o),
        .o_pe_data(pe_data_o), .o_pe_local(pe_local), .o_pe_valid(pe_valid_o), .i_pe_ready(pe_ready_i),
        .o_tx_count(tx_count), .o_rx_count(rx_count), .o_misroute(misroute)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: per-stream ordered queues and expected totals.
    logic [35:0] exp_noc[$];
    logic [31:0] exp_loop[$];
    logic [31:0] exp_rxn[$];
    logic [32:0] rxq[$];
    logic [35:0] e36;
    logic [31:0] e32;
    logic [32:0] e33;
    logic [15:0] tx_exp, rx_exp;
    logic        mis_exp, inj, nf, pf, rf, tf;
    int          got, ncnt, lcnt;

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pe_data = '0; pe_dest = '0; pe_valid = 1'b0;
        noc_ready_i = 1'b0; noc_data_i = '0; noc_valid_i = 1'b0; pe_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_noc_valid", 64'(noc_valid_o), 64'h0);
        chk("rst_pe_valid",  64'(pe_valid_o),  64'h0);
        chk("rst_pe_data",   64'(pe_data_o),   64'h0);
        chk("rst_pe_local",  64'(pe_local),    64'h0);
        chk("rst_noc_data",  64'(noc_data_o),  64'h0);
        chk("rst_tx_count",  64'(tx_count),    64'h0);
        chk("rst_rx_count",  64'(rx_count),    64'h0);
        chk("rst_misroute",  64'(misroute),    64'h0);
        chk("rst_pe_ready",  64'(pe_ready),    64'h1);
        chk("rst_noc_ready", 64'(noc_ready_o), 64'h1);
        rst = 1'b0;
        tick();

        // Single remote flit: visible one edge after acceptance, then counted.
        noc_ready_i = 1'b1; pe_data = 32'hA5A5_0001; pe_dest = 4'h3; pe_valid = 1'b1;
        tick();
        pe_valid = 1'b0;
        chk("tx_first_valid", 64'(noc_valid_o), 64'h1);
        chk("tx_first_data",  64'(noc_data_o),  64'h3_A5A5_0001);
        tick();
        chk("tx_first_count", 64'(tx_count),    64'h1);
        chk("tx_first_drain", 64'(noc_valid_o), 64'h0);

        // Fill TX under NoC backpressure, then release and check order.
        noc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pe_data = 32'hB000_0000 + 32'(i); pe_dest = 4'h5; pe_valid = 1'b1;
            exp_noc.push_back({pe_dest, pe_data});
            if (i < 4) begin
                chk("tx_fill_ready", 64'(pe_ready), 64'h1);
                tick();
            end else begin
                chk("tx_full_ready", 64'(pe_ready), 64'h0);
            end
        end
        noc_ready_i = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (noc_valid_o && noc_ready_i) begin
                e36 = (exp_noc.size() != 0) ? exp_noc.pop_front() : 'x;
                chk("tx_order", 64'(noc_data_o), 64'(e36));
                got++;
            end
            pf = pe_valid && pe_ready;
            tick();
            if (pf) pe_valid = 1'b0;
        end
        chk("tx_order_count", 64'(got),      64'h5);
        chk("tx_count_6",     64'(tx_count), 64'h6);

        // Loopback of a self-addressed payload.
        pe_data = 32'h0000_1234; pe_dest = 4'h0; pe_valid = 1'b1;
        tick();
        pe_valid = 1'b0;
        chk("loop_n_noc_valid", 64'(noc_valid_o), 64'h0);
        chk("loop_n_pe_valid",  64'(pe_valid_o),  64'h0);
        tick();
        chk("loop_pe_valid",  64'(pe_valid_o),  64'h1);
        chk("loop_pe_data",   64'(pe_data_o),   64'h1234);
        chk("loop_pe_local",  64'(pe_local),    64'h1);
        chk("loop_noc_valid", 64'(noc_valid_o), 64'h0);
        pe_ready_i = 1'b1;
        tick();
        pe_ready_i = 1'b0;
        chk("loop_popped",   64'(pe_valid_o), 64'h0);
        chk("loop_rx_count", 64'(rx_count),   64'h1);

        // Contested RX arbitration: NoC and loopback alternate every cycle.
        pe_ready_i = 1'b1; pe_dest = 4'h0; pe_data = 32'h200; pe_valid = 1'b1;
        tick();
        lcnt = 1; pe_data = 32'h201;
        noc_valid_i = 1'b1; noc_data_i = {4'h0, 32'h100}; ncnt = 0;
        rxq.delete();
        for (int c = 0; c < 10; c++) begin
            nf = noc_valid_i && noc_ready_o;
            pf = pe_valid && pe_ready;
            if (pe_valid_o && pe_ready_i) rxq.push_back({pe_local, pe_data_o});
            tick();
            if (nf) begin ncnt++; noc_data_i = {4'h0, 32'h100 + 32'(ncnt)}; end
            if (pf) begin lcnt++; pe_data = 32'h200 + 32'(lcnt); end
        end
        chk("arb_rx_every_cycle", 64'(rx_count), 64'd11);
        pe_valid = 1'b0; noc_valid_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (pe_valid_o && pe_ready_i) rxq.push_back({pe_local, pe_data_o});
            tick();
        end
        chk("arb_noc_count", 64'(ncnt),       64'd5);
        chk("arb_rx_total",  64'(rxq.size()), 64'(ncnt + lcnt));
        for (int j = 0; j < rxq.size(); j++) begin
            if (j < 10) e33 = (j % 2 == 1) ? {1'b1, 32'h200 + 32'(j / 2)} : {1'b0, 32'h100 + 32'(j / 2)};
            else        e33 = {1'b1, 32'h205 + 32'(j - 10)};
            chk("arb_rx_order", 64'(rxq[j]), 64'(e33));
        end
        rx_exp = 16'(1 + ncnt + lcnt);
        chk("arb_rx_count",  64'(rx_count),   64'(rx_exp));
        chk("arb_rx_idle",   64'(pe_valid_o), 64'h0);

        // Misrouted ejection: accepted, dropped, sticky flag.
        noc_valid_i = 1'b1; noc_data_i = {4'h7, 32'hDEAD};
        chk("mis_ready", 64'(noc_ready_o), 64'h1);
        tick();
        noc_valid_i = 1'b0;
        chk("mis_flag",     64'(misroute),   64'h1);
        chk("mis_no_valid", 64'(pe_valid_o), 64'h0);
        repeat (3) tick();
        chk("mis_sticky",   64'(misroute),   64'h1);
        chk("mis_no_count", 64'(rx_count),   64'(rx_exp));
        chk("mis_still_no_valid", 64'(pe_valid_o), 64'h0);

        // Reset with both FIFOs full.
        pe_ready_i = 1'b0; noc_ready_i = 1'b0;
        pe_valid = 1'b1; pe_dest = 4'h5; noc_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pe_data = 32'h300 + 32'(i); noc_data_i = {4'h0, 32'h400 + 32'(i)};
            tick();
        end
        pe_valid = 1'b0; noc_valid_i = 1'b0;
        chk("full_pe_ready",  64'(pe_ready),    64'h0);
        chk("full_noc_ready", 64'(noc_ready_o), 64'h0);
        chk("full_noc_valid", 64'(noc_valid_o), 64'h1);
        chk("full_pe_valid",  64'(pe_valid_o),  64'h1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_pe_valid",  64'(pe_valid_o),  64'h0);
        chk("mrst_noc_valid", 64'(noc_valid_o), 64'h0);
        chk("mrst_tx_count",  64'(tx_count),    64'h0);
        chk("mrst_rx_count",  64'(rx_count),    64'h0);
        chk("mrst_pe_ready",  64'(pe_ready),    64'h1);
        chk("mrst_noc_ready", 64'(noc_ready_o), 64'h1);
        chk("mrst_misroute",  64'(misroute),    64'h0);
        chk("mrst_pe_data",   64'(pe_data_o),   64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against per-stream ordered queues.
        tx_exp = '0; rx_exp = '0; mis_exp = 1'b0;
        exp_noc.delete(); exp_loop.delete(); exp_rxn.delete();
        for (int c = 0; c < 460; c++) begin
            inj = (c < 400);
            tf = noc_valid_o && noc_ready_i;
            rf = pe_valid_o && pe_ready_i;
            pf = pe_valid && pe_ready;
            nf = noc_valid_i && noc_ready_o;
            if (tf) begin
                e36 = (exp_noc.size() != 0) ? exp_noc.pop_front() : 'x;
                chk("rand_tx", 64'(noc_data_o), 64'(e36));
                tx_exp++;
            end
            if (rf) begin
                if (pe_local) begin
                    e32 = (exp_loop.size() != 0) ? exp_loop.pop_front() : 'x;
                    chk("rand_rx_loop", 64'(pe_data_o), 64'(e32));
                end else begin
                    e32 = (exp_rxn.size() != 0) ? exp_rxn.pop_front() : 'x;
                    chk("rand_rx_noc", 64'(pe_data_o), 64'(e32));
                end
            end
            if (pf) begin
                if (pe_dest == 4'h0) begin exp_loop.push_back(pe_data); rx_exp++; end
                else exp_noc.push_back({pe_dest, pe_data});
            end
            if (nf) begin
                if (noc_data_i[35:32] == 4'h0) begin exp_rxn.push_back(noc_data_i[31:0]); rx_exp++; end
                else mis_exp = 1'b1;
            end
            tick();
            if (pf || !pe_valid) begin
                pe_valid = inj && ($urandom_range(0, 3) != 0);
                pe_data  = $urandom;
                pe_dest  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if (nf || !noc_valid_i) begin
                noc_valid_i = inj && ($urandom_range(0, 2) != 0);
                noc_data_i  = {(($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0), $urandom};
            end
            noc_ready_i = !inj || ($urandom_range(0, 3) != 0);
            pe_ready_i  = !inj || ($urandom_range(0, 3) != 0);
        end
        chk("rand_tx_count",  64'(tx_count),        64'(tx_exp));
        chk("rand_rx_count",  64'(rx_count),        64'(rx_exp));
        chk("rand_misroute",  64'(misroute),        64'(mis_exp));
        chk("rand_tx_left",   64'(exp_noc.size()),  64'h0);
        chk("rand_loop_left", 64'(exp_loop.size()), 64'h0);
        chk("rand_rxn_left",  64'(exp_rxn.size()),  64'h0);
        chk("rand_idle_rx",   64'(pe_valid_o),      64'h0);
        chk("rand_idle_tx",   64'(noc_valid_o),     64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_pe_interface.md
# noc_pe_interface

PE-side network interface sitting between one processing element and one PE port of the 16-PE hierarchical NoC (the i_pe_data*/o_pe_data* port set of the top level). Packs PE payload plus destination into a flit {dest, data}, buffers it and injects it into the NoC. Buffers ejected flits and strips the address before delivering the payload to the PE. Self-addressed traffic loops back locally without entering the NoC.

## Interface
- DataWidth, 32, payload width
- AddrWidth, 4, PE address width; flit width FW = DataWidth+AddrWidth, dest in flit[FW-1:DataWidth]
- MyAddr, 0, address of the attached PE
- FifoDepth, 4, entries per FIFO; power of two, >= 2

- i_clk  in  1  single clock for the whole block
- i_reset  in  1  asynchronous, active-high reset
- i_pe_data  in  DataWidth  TX payload from PE
- i_pe_dest  in  AddrWidth  TX destination PE address
- i_pe_valid  in  1  TX payload valid
- o_pe_ready  out  1  TX FIFO can accept
- o_noc_data  out  FW  flit to NoC port (connects to i_pe_dataN)
- o_noc_valid  out  1  flit valid
- i_noc_ready  in  1  NoC accepts flit
- i_noc_data  in  FW  flit from NoC port (connects to o_pe_dataN)
- i_noc_valid  in  1  ejected flit valid
- o_noc_ready  out  1  block accepts ejected flit
- o_pe_data  out  DataWidth  RX payload to PE
- o_pe_local  out  1  RX payload came via loopback
- o_pe_valid  out  1  RX payload valid
- i_pe_ready  in  1  PE accepts RX payload
- o_tx_count  out  16  flits injected into NoC, wraps at 2^16
- o_rx_count  out  16  payloads written into RX FIFO (both sources), wraps
- o_misroute  out  1  sticky: NoC delivered a flit with dest != MyAddr

## Operation
- All transfers: handshake completes on rising i_clk when valid && ready. Valid, once high, holds with stable data until accepted.
- TX FIFO stores {dest, data}. o_pe_ready = !tx_full; no pop-bypass: full FIFO stays not-ready even on a same-cycle pop.
- TX head with dest != MyAddr: o_noc_valid = 1, o_noc_data = head; pop on NoC handshake, o_tx_count += 1.
- TX head with dest == MyAddr: o_noc_valid = 0; head raises loopback request to RX arbiter. Head-of-line blocking is intended; no reordering.
- RX arbiter, two requesters: NoC (i_noc_valid) and loopback. One write per cycle, only when !rx_full. Round-robin: 1-bit priority pointer; when both request, pointer side wins, then pointer moves to the other side. Single requester wins regardless of pointer and leaves pointer unchanged. Pointer resets to NoC.
- o_noc_ready = !rx_full && !(loop_req && prio == loop); independent of i_noc_valid.
- NoC flit with dest == MyAddr: data written to RX FIFO with local = 0. Dest != MyAddr: accepted, discarded, o_misroute set, no count.
- RX FIFO stores {local, data}; o_pe_valid = !rx_empty; pop on PE handshake.
- Counters increment at most once per cycle each; 16'hFFFF + 1 -> 0.

## Timing
- Reset values: o_noc_valid 0, o_pe_valid 0, o_pe_data 0, o_pe_local 0, o_noc_data 0, counters 0, o_misroute 0, o_pe_ready 1, o_noc_ready 1.
- Reset asserted mid-operation: both FIFOs flush immediately, in-flight data lost, priority pointer -> NoC.
- PE TX accepted at edge N -> o_noc_valid high after edge N (1-cycle latency); no fall-through from empty.
- Loopback: accepted at edge N, RX write at edge N+1 if granted -> o_pe_valid after N+1.
- NoC ejection accepted at edge N -> o_pe_valid after edge N.
- Full throughput: one flit per cycle per direction when no backpressure.

## Structure
- Package noc_pkg: FW localparam function, flit_dest()/flit_data() extract functions, flit packing function; shared by the NoC top and this block.
- Sub-module sync_fifo (params Width, Depth; full/empty, registered storage, no bypass), instantiated twice (TX width FW, RX width DataWidth+1).
- Arbiter and counters inline.

## Test plan
- Reset, MyAddr=0: send data 32'hA5A5_0001 dest 3, i_noc_ready=1 -> o_noc_data = {4'h3, 32'hA5A5_0001} one cycle later, o_tx_count = 1.
- i_noc_ready=0, push 5 flits with FifoDepth=4 -> o_pe_ready drops after 4th; release ready -> 4 flits emitted in order, then 5th.
- Send dest 0 (= MyAddr) data 32'h1234 -> o_pe_valid 2 cycles later, o_pe_data 32'h1234, o_pe_local 1, o_noc_valid never high.
- Continuous loopback and NoC ejection together, i_pe_ready=1 -> RX order alternates NoC, loop, NoC, loop; o_rx_count increments every cycle.
- Inject NoC flit {4'h7, 32'hDEAD} -> accepted, o_pe_valid stays 0, o_misroute 1 until reset.
- Assert i_reset with both FIFOs full -> immediately o_pe_valid 0, o_noc_valid 0, counters 0, both ready 1.
